// File: rtl/gray_mon_pkg.sv
// Shared types and helpers for the Gray-code monitor.
// The optional debounce path is enabled by defining GRAY_MON_DEBOUNCE_EN.
package gray_mon_pkg;

   localparam int GRAY_W = 3;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      HOLD = 2'd0,
      FWD  = 2'd1,
      BWD  = 2'd2,
      ILL  = 2'd3
   } xclass_t;

   // Classifies a move between two decoded binary values; the difference
   // wraps modulo 2^GRAY_W, so 7->0 is a forward step and 0->7 a backward one.
   function automatic xclass_t classify(input logic [GRAY_W-1:0] b_new,
                                        input logic [GRAY_W-1:0] b_old);
      logic [GRAY_W-1:0] d;
      d = b_new - b_old;
      if (d == '0)
         return HOLD;
      else if (d == GRAY_W'(1))
         return FWD;
      else if (d == '1)
         return BWD;
      else
         return ILL;
   endfunction

endpackage

// File: rtl/gray_mon_if.sv
// Signal bundle between the Gray counter side (master) and the monitor (slave).
// Gray_In has no valid/ready: it is a free-running code sampled on every Clk edge.
interface gray_mon_if
   import gray_mon_pkg::*;
#(
   parameter int LAP_W = 8
) ();

   logic [GRAY_W-1:0] Gray_In;
   logic [GRAY_W-1:0] Bin_Out;
   logic              Step;
   logic              Back;
   logic              Err;
   logic [LAP_W-1:0]  Lap_Cnt;

   modport master (
      output Gray_In,
      input  Bin_Out, Step, Back, Err, Lap_Cnt
   );

   modport slave (
      input  Gray_In,
      output Bin_Out, Step, Back, Err, Lap_Cnt
   );

endinterface

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decode: each binary bit is the XOR of all
// Gray bits at or above its position.
module gray_to_bin
   import gray_mon_pkg::*;
(
   input  logic [GRAY_W-1:0] gray,
   output logic [GRAY_W-1:0] bin
);

   for (genvar i = 0; i < GRAY_W; i++) begin : g_bit
      assign bin[i] = ^gray[GRAY_W-1:i];
   end

endmodule

// File: rtl/gray_monitor.sv
// Gray-code monitor: decodes the upstream counter, flags forward/backward steps,
// counts forward laps and latches illegal moves. Debounce: GRAY_MON_DEBOUNCE_EN.
module gray_monitor
   import gray_mon_pkg::*;
#(
   parameter int LAP_W = 8
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Clr,
   gray_mon_if.slave  mon,
   output state_t     dbg_state
);

   localparam logic [LAP_W-1:0] LAP_MAX = '1;

   state_t            state_q;
   logic [GRAY_W-1:0] g_q;
   logic [GRAY_W-1:0] bin_q;
   logic              step_q;
   logic              back_q;
   logic              err_q;
   logic [LAP_W-1:0]  lap_q;

   logic [GRAY_W-1:0] code_in;
   logic [GRAY_W-1:0] b_new;
   logic [GRAY_W-1:0] b_old;
   logic              stable;
   xclass_t           xc;

`ifdef GRAY_MON_DEBOUNCE_EN
   // A new code counts only once it has been seen on two consecutive edges.
   logic [GRAY_W-1:0] cand_q;
   assign stable = (mon.Gray_In == cand_q);
`else
   assign stable = 1'b1;
`endif

   // INIT always loads the raw input; otherwise an unsettled code looks like a hold.
   assign code_in = (state_q == INIT || stable) ? mon.Gray_In : g_q;

   gray_to_bin u_new (.gray(code_in), .bin(b_new));
   gray_to_bin u_old (.gray(g_q),     .bin(b_old));

   assign xc = classify(b_new, b_old);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= INIT;
         g_q     <= '0;
         bin_q   <= '0;
         step_q  <= 1'b0;
         back_q  <= 1'b0;
         err_q   <= 1'b0;
         lap_q   <= '0;
`ifdef GRAY_MON_DEBOUNCE_EN
         cand_q  <= '0;
`endif
      end else begin
         step_q <= 1'b0;
         back_q <= 1'b0;
`ifdef GRAY_MON_DEBOUNCE_EN
         cand_q <= mon.Gray_In;
`endif
         if (Clr) begin
            state_q <= INIT;
            err_q   <= 1'b0;
            lap_q   <= '0;
         end else begin
            case (state_q)
               INIT: begin
                  g_q     <= code_in;
                  bin_q   <= b_new;
                  state_q <= TRACK;
               end
               TRACK: begin
                  g_q <= code_in;
                  case (xc)
                     FWD: begin
                        step_q <= 1'b1;
                        bin_q  <= b_new;
                        if (b_old == '1 && lap_q != LAP_MAX)
                           lap_q <= lap_q + LAP_W'(1);
                     end
                     BWD: begin
                        back_q <= 1'b1;
                        bin_q  <= b_new;
                     end
                     ILL: begin
                        err_q   <= 1'b1;
                        bin_q   <= b_new;
                        state_q <= FAULT;
                     end
                     default: ;
                  endcase
               end
               FAULT: begin
                  g_q   <= code_in;
                  bin_q <= b_new;
               end
               default: state_q <= INIT;
            endcase
         end
      end
   end

   assign mon.Bin_Out = bin_q;
   assign mon.Step    = step_q;
   assign mon.Back    = back_q;
   assign mon.Err     = err_q;
   assign mon.Lap_Cnt = lap_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_gray_monitor.sv
// Self-checking bench for gray_monitor: directed vector tables, hand sequences,
// and randomized codes checked against a modulo-8 step model.
module tb_gray_monitor;
  import gray_mon_pkg::*;

  logic   Clk;
  logic   Reset;
  logic   clr;
  state_t st8;
  state_t st2;

  gray_mon_if #(.LAP_W(8)) if8 ();
  gray_mon_if #(.LAP_W(2)) if2 ();

  gray_monitor #(.LAP_W(8)) u_dut8 (
    .Clk(Clk), .Reset(Reset), .Clr(clr), .mon(if8), .dbg_state(st8)
  );
  gray_monitor #(.LAP_W(2)) u_dut2 (
    .Clk(Clk), .Reset(Reset), .Clr(clr), .mon(if2), .dbg_state(st2)
  );

  // clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // behavioural reference: positions on the 8-entry Gray cycle
  int         m_mode;   // 0 INIT, 1 TRACK, 2 FAULT
  int         m_bin, m_step, m_back, m_err, m_lap8, m_lap2;
  logic [2:0] m_last, m_cand;

  function automatic int g2i(input logic [2:0] g);
    for (int i = 0; i < 8; i++)
      if ((i ^ (i >> 1)) == int'(g)) return i;
    return -1;
  endfunction

  function automatic logic [2:0] i2g(input int i);
    int v;
    v = (i % 8) ^ ((i % 8) >> 1);
    return v[2:0];
  endfunction

  task automatic model_reset();
    m_mode = 0; m_bin = 0; m_step = 0; m_back = 0; m_err = 0;
    m_lap8 = 0; m_lap2 = 0; m_last = 3'b000; m_cand = 3'b000;
  endtask

  task automatic model_edge(input logic [2:0] g, input logic c);
    int nb, ob, d;
    logic [2:0] code;
    logic stab;
`ifdef GRAY_MON_DEBOUNCE_EN
    stab = (g == m_cand);
`else
    stab = 1'b1;
`endif
    m_step = 0;
    m_back = 0;
    if (c) begin
      m_mode = 0; m_err = 0; m_lap8 = 0; m_lap2 = 0;
    end else if (m_mode == 0) begin
      m_last = g; m_bin = g2i(g); m_mode = 1;
    end else begin
      code = stab ? g : m_last;
      nb = g2i(code);
      ob = g2i(m_last);
      d = (nb - ob + 8) % 8;
      m_last = code;
      if (m_mode == 2) begin
        m_bin = nb;
      end else if (d == 1) begin
        m_step = 1; m_bin = nb;
        if (ob == 7) begin
          if (m_lap8 < 255) m_lap8++;
          if (m_lap2 < 3) m_lap2++;
        end
      end else if (d == 7) begin
        m_back = 1; m_bin = nb;
      end else if (d != 0) begin
        m_err = 1; m_mode = 2; m_bin = nb;
      end
    end
    m_cand = g;
  endtask

  // scoreboard
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("bin8",  int'(if8.Bin_Out), m_bin);
    chk("step8", int'(if8.Step),    m_step);
    chk("back8", int'(if8.Back),    m_back);
    chk("err8",  int'(if8.Err),     m_err);
    chk("lap8",  int'(if8.Lap_Cnt), m_lap8);
    chk("st8",   int'(st8),         m_mode);
    chk("bin2",  int'(if2.Bin_Out), m_bin);
    chk("lap2",  int'(if2.Lap_Cnt), m_lap2);
    chk("st2",   int'(st2),         m_mode);
    chk("step_and_back", int'(if8.Step & if8.Back), 0);
  endtask

  // driver: one code per clock, outputs sampled 1 time unit after the edge
  task automatic tick(input logic [2:0] g, input logic c);
    if8.Gray_In = g;
    if2.Gray_In = g;
    clr = c;
    @(posedge Clk);
    model_edge(g, c);
    #1;
    compare_all();
  endtask

  typedef struct {
    logic [2:0] g;
    logic       c;
    int         bin, step, back, err, lap, st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [2:0] g, input logic c, input int bin,
                              input int step, input int back, input int err,
                              input int lap, input int st);
    vec_t v;
    v.g = g; v.c = c; v.bin = bin; v.step = step; v.back = back;
    v.err = err; v.lap = lap; v.st = st;
    return v;
  endfunction

  int cur_idx;
  int r;

  initial begin
    Reset = 1'b1;
    clr = 1'b0;
    if8.Gray_In = 3'b000;
    if2.Gray_In = 3'b000;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    compare_all();
    #2 Reset = 1'b0;

`ifndef GRAY_MON_DEBOUNCE_EN
    //            g       c     bin s  b  e  lap st
    tbl.push_back(mk(3'b000, 1'b0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(3'b001, 1'b0, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(3'b011, 1'b0, 2, 1, 0, 0, 0, 1));
    tbl.push_back(mk(3'b010, 1'b0, 3, 1, 0, 0, 0, 1));
    tbl.push_back(mk(3'b110, 1'b0, 4, 1, 0, 0, 0, 1));
    tbl.push_back(mk(3'b111, 1'b0, 5, 1, 0, 0, 0, 1));
    tbl.push_back(mk(3'b101, 1'b0, 6, 1, 0, 0, 0, 1));
    tbl.push_back(mk(3'b100, 1'b0, 7, 1, 0, 0, 0, 1));
    tbl.push_back(mk(3'b000, 1'b0, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(3'b001, 1'b0, 1, 1, 0, 0, 1, 1));
    tbl.push_back(mk(3'b011, 1'b0, 2, 1, 0, 0, 1, 1));
    tbl.push_back(mk(3'b010, 1'b0, 3, 1, 0, 0, 1, 1));
    tbl.push_back(mk(3'b011, 1'b0, 2, 0, 1, 0, 1, 1));
    tbl.push_back(mk(3'b001, 1'b0, 1, 0, 1, 0, 1, 1));
    tbl.push_back(mk(3'b000, 1'b0, 0, 0, 1, 0, 1, 1));
    tbl.push_back(mk(3'b100, 1'b0, 7, 0, 1, 0, 1, 1));
    tbl.push_back(mk(3'b000, 1'b0, 0, 1, 0, 0, 2, 1));
    tbl.push_back(mk(3'b000, 1'b0, 0, 0, 0, 0, 2, 1));
    tbl.push_back(mk(3'b010, 1'b0, 3, 0, 0, 1, 2, 2));
    tbl.push_back(mk(3'b110, 1'b0, 4, 0, 0, 1, 2, 2));
    tbl.push_back(mk(3'b111, 1'b0, 5, 0, 0, 1, 2, 2));
    tbl.push_back(mk(3'b101, 1'b0, 6, 0, 0, 1, 2, 2));
    tbl.push_back(mk(3'b100, 1'b0, 7, 0, 0, 1, 2, 2));
    tbl.push_back(mk(3'b000, 1'b0, 0, 0, 0, 1, 2, 2));
    tbl.push_back(mk(3'b000, 1'b1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3'b001, 1'b0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(3'b011, 1'b0, 2, 1, 0, 0, 0, 1));
    tbl.push_back(mk(3'b110, 1'b1, 2, 0, 0, 0, 0, 0));
    tbl.push_back(mk(3'b110, 1'b0, 4, 0, 0, 0, 0, 1));
    tbl.push_back(mk(3'b111, 1'b0, 5, 1, 0, 0, 0, 1));
`else
    // glitch 000->011->000 is ignored; a held 001 steps on its second edge
    tbl.push_back(mk(3'b000, 1'b0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(3'b011, 1'b0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(3'b000, 1'b0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(3'b000, 1'b0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(3'b001, 1'b0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(3'b001, 1'b0, 1, 1, 0, 0, 0, 1));
    tbl.push_back(mk(3'b001, 1'b0, 1, 0, 0, 0, 0, 1));
`endif

    foreach (tbl[i]) begin
      tick(tbl[i].g, tbl[i].c);
      chk($sformatf("tbl%0d_bin", i),  int'(if8.Bin_Out), tbl[i].bin);
      chk($sformatf("tbl%0d_step", i), int'(if8.Step),    tbl[i].step);
      chk($sformatf("tbl%0d_back", i), int'(if8.Back),    tbl[i].back);
      chk($sformatf("tbl%0d_err", i),  int'(if8.Err),     tbl[i].err);
      chk($sformatf("tbl%0d_lap", i),  int'(if8.Lap_Cnt), tbl[i].lap);
      chk($sformatf("tbl%0d_st", i),   int'(st8),         tbl[i].st);
    end

    // randomized walk: mostly legal steps, some holds, jumps and clears
    cur_idx = g2i(if8.Gray_In);
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      if (r <= 11)      cur_idx = (cur_idx + 1) % 8;
      else if (r <= 15) cur_idx = (cur_idx + 7) % 8;
      else if (r == 18) cur_idx = $urandom_range(0, 7);
      tick(i2g(cur_idx), (r == 19) ? 1'b1 : 1'b0);
    end

    // asynchronous reset between edges, then restart on Gray 110
    #2 Reset = 1'b1;
    model_reset();
    #1;
    chk("arst_bin",  int'(if8.Bin_Out), 0);
    chk("arst_step", int'(if8.Step),    0);
    chk("arst_back", int'(if8.Back),    0);
    chk("arst_err",  int'(if8.Err),     0);
    chk("arst_lap",  int'(if8.Lap_Cnt), 0);
    chk("arst_st",   int'(st8),         0);
    if8.Gray_In = 3'b110;
    if2.Gray_In = 3'b110;
    #1 Reset = 1'b0;
    tick(3'b110, 1'b0);
    chk("post_rst_bin",  int'(if8.Bin_Out), 4);
    chk("post_rst_step", int'(if8.Step),    0);
    chk("post_rst_err",  int'(if8.Err),     0);

    // five laps, each code held two edges so both build options advance
    tick(3'b000, 1'b1);
    tick(3'b000, 1'b0);
    for (int lap = 0; lap < 5; lap++)
      for (int k = 1; k <= 8; k++) begin
        tick(i2g(k), 1'b0);
        tick(i2g(k), 1'b0);
      end
    chk("lap8_five", int'(if8.Lap_Cnt), 5);
    chk("lap2_sat",  int'(if2.Lap_Cnt), 3);
    chk("laps_err",  int'(if8.Err),     0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
